sfr_ext: RTL
============

Name: sfr_ext

Overview:
Parametrised special-function-register block for the sigma tile, successor to the basic SFR. Sits on the tile's MemSplit32 slave port and provides ID/core-number readout, CPU reset control, a buffered MSI queue with downstream handshake, a programmable down-counting timer with interrupt, and a configurable bank of scratch registers. All registers are 32-bit, word-aligned, and decoded on addr[7:0].

Parameters:
CORENUM, 0, core index returned by the CORENUM register
CPU_RESET_DEFAULT, 0, value of the cpu_reset control bit after rst_i
IRQ_NUM_POW, 4, width of the MSI code
MSI_FIFO_DEPTH_POW, 2, log2 of the MSI FIFO depth (default depth 4); legal range 1..6
NUM_SCRATCH, 4, number of scratch registers; legal range 0..56
TIMER_WIDTH, 32, timer counter width; legal range 1..32

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
host  interface  MemSplit32.Slave  register access port (req, ack, we, addr, wdata, be, resp, rdata)
cpu_reset_o  output  1  registered rst_i | cpu_reset
msi_req_o  output  1  MSI FIFO non-empty
msi_code_bo  output  IRQ_NUM_POW  MSI code at FIFO head
msi_ack_i  input  1  consumer accepts head entry
timer_irq_o  output  1  timer interrupt, level

Behaviour:
- Reset values: resp=0, rdata=0, cpu_reset=CPU_RESET_DEFAULT, FIFO empty, overflow=0, timer ctrl/period/value=0, irq flag=0, scratch=0. msi_req_o=0 and msi_code_bo=0 while the FIFO is empty. cpu_reset_o=1 on the cycle after rst_i is asserted.
- Host handshake: ack=req, combinational. Reads: resp=1 and rdata are valid exactly one cycle after req&!we. Writes: no resp; take effect on the next edge. be is ignored; full-word writes only. Unmapped reads return 0. Unmapped writes are ignored.
- Register map:
  - 0x00 IDCODE RO 32'h5F120002.
  - 0x04 CTRL RW [0]=cpu_reset.
  - 0x08 CORENUM RO.
  - 0x0C MSI WO: pushes wdata[IRQ_NUM_POW-1:0].
  - 0x10 MSI_STAT: [0]=empty, [1]=full, [2]=overflow (W1C), [15:8]=count.
  - 0x14 TMR_CTRL: [0]=enable, [1]=autoreload, [2]=irq_en, [3]=irq flag (W1C; writing 0 has no effect).
  - 0x18 TMR_PERIOD RW. A write also loads the counter value with wdata.
  - 0x1C TMR_VALUE RO.
  - 0x20+4*i SCRATCH[i] RW, for i<NUM_SCRATCH.
- MSI FIFO:
  - Push is accepted if count<depth, or if a pop occurs in the same cycle.
  - A push to a full FIFO with no pop is dropped and sets overflow. Overflow is sticky until W1C.
  - Pop occurs when msi_req_o & msi_ack_i.
  - Write at cycle N on an empty FIFO gives msi_req_o=1 at N+1.
  - Pointers wrap modulo depth; count is DEPTH_POW+1 bits.
  - Push and pop in the same cycle leave count unchanged.
  - Entries keep FIFO order.
- Timer:
  - While enable=1, value decrements by 1 per cycle.
  - On a cycle where enable=1 and value==0: the irq flag is set. If autoreload=1, value<=period; otherwise enable<=0 and value stays 0.
  - period=0 with autoreload=1 sets the flag every cycle.
  - timer_irq_o = flag & irq_en, registered from the flag.
  - If the flag is set and cleared in the same cycle, set wins.
  - A TMR_PERIOD write in the same cycle as a terminal count: the write wins for value.
- Reset mid-operation: all state returns to reset values on the next edge, FIFO contents are discarded, and a read pending in that cycle gets no resp.
- Width rules: timer registers read zero-extended from TIMER_WIDTH; writes truncate. CORENUM is zero-extended.

Optional Feature:
SFR_TIMER_EN:
- Defined: timer registers and logic are present as described.
- Undefined: no timer logic is synthesised, 0x14/0x18/0x1C read 0 and ignore writes, and timer_irq_o is tied to 0.

Test Plan:
1. Read 0x00, 0x08 with CORENUM=3 -> resp one cycle after req, rdata 32'h5F120002 then 3. Read 0x40 with NUM_SCRATCH=4 -> rdata 0.
2. Write CTRL=1 then 0 -> cpu_reset_o goes 1 two cycles after the write, then returns to 0. Assert rst_i -> cpu_reset_o=1 next cycle.
3. msi_ack_i=0, write MSI codes 1,2,3,4,5 (depth 4) -> MSI_STAT reads full=1, count=4, overflow=1. Then ack each cycle -> msi_code_bo 1,2,3,4, then msi_req_o=0.
4. FIFO full, push 7 with msi_ack_i=1 in the same cycle -> no overflow, count stays 4, 7 is the last entry popped.
5. PERIOD=3, CTRL=0x7 -> timer_irq_o rises after counting 3,2,1,0 and repeats every 4 cycles. Write CTRL=0x8|0x7 -> irq clears for one period. With autoreload=0 -> a single irq, then enable reads 0.
6. SCRATCH[0..3] write 0xA5A5_0000+i, then read back -> matching values. Assert rst_i -> all read 0.

Source files
------------

// File: rtl/sfr_ext.sv
// sfr_ext: special-function registers for the sigma tile (ID, CPU reset, MSI FIFO, timer, scratch).
// Optional timer logic is built only when SFR_TIMER_EN is defined.
module sfr_ext #(
    parameter int unsigned CORENUM            = 0,
    parameter bit          CPU_RESET_DEFAULT  = 1'b0,
    parameter int          IRQ_NUM_POW        = 4,
    parameter int          MSI_FIFO_DEPTH_POW = 2,
    parameter int          NUM_SCRATCH        = 4,
    parameter int          TIMER_WIDTH        = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   host_req,
    output logic                   host_ack,
    input  logic                   host_we,
    input  logic [31:0]            host_addr,
    input  logic [31:0]            host_wdata,
    input  logic [3:0]             host_be,
    output logic                   host_resp,
    output logic [31:0]            host_rdata,
    output logic                   cpu_reset_o,
    output logic                   msi_req_o,
    output logic [IRQ_NUM_POW-1:0] msi_code_bo,
    input  logic                   msi_ack_i,
    output logic                   timer_irq_o
);

    localparam int          DEPTH  = 1 << MSI_FIFO_DEPTH_POW;
    localparam int          SCR_N  = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam logic [31:0] IDCODE = 32'h5F12_0002;

    logic [5:0] word;
    logic       wr;
    logic       rd;

    assign word     = host_addr[7:2];
    assign wr       = host_req & host_we;
    assign rd       = host_req & ~host_we;
    assign host_ack = host_req;

    // Byte enables and the upper/lower address bits play no part in decode.
    logic unused_bits;
    assign unused_bits = ^{host_be, host_addr[31:8], host_addr[1:0]};

    logic                          cpu_reset;
    logic [IRQ_NUM_POW-1:0]        fifo_mem [DEPTH];
    logic [MSI_FIFO_DEPTH_POW-1:0] wr_ptr;
    logic [MSI_FIFO_DEPTH_POW-1:0] rd_ptr;
    logic [MSI_FIFO_DEPTH_POW:0]   count;
    logic                          overflow;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic                          push;
    logic                          pop;
    logic                          push_ok;
    logic [31:0]                   scratch [SCR_N];
    logic [5:0]                    scr_idx;
    logic                          scr_hit;
    logic [31:0]                   rdata_next;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == (MSI_FIFO_DEPTH_POW + 1)'(DEPTH));
    assign push        = wr & (word == 6'h03);
    assign pop         = ~fifo_empty & msi_ack_i;
    assign push_ok     = push & (~fifo_full | pop);
    assign msi_req_o   = ~fifo_empty;
    assign msi_code_bo = fifo_empty ? '0 : fifo_mem[rd_ptr];

    assign scr_idx = word - 6'd8;
    assign scr_hit = (word >= 6'd8) && (int'(scr_idx) < NUM_SCRATCH);

`ifdef SFR_TIMER_EN
    logic                   tmr_en;
    logic                   tmr_ar;
    logic                   tmr_ie;
    logic                   tmr_flag;
    logic                   tmr_irq;
    logic [TIMER_WIDTH-1:0] tmr_period;
    logic [TIMER_WIDTH-1:0] tmr_value;
    logic                   tmr_tc;

    assign tmr_tc = tmr_en & (tmr_value == '0);

    // Host writes are applied after the counter update so they take priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmr_en     <= 1'b0;
            tmr_ar     <= 1'b0;
            tmr_ie     <= 1'b0;
            tmr_flag   <= 1'b0;
            tmr_irq    <= 1'b0;
            tmr_period <= '0;
            tmr_value  <= '0;
        end else begin
            if (tmr_en) begin
                if (tmr_value == '0) begin
                    if (tmr_ar) tmr_value <= tmr_period;
                    else        tmr_en    <= 1'b0;
                end else begin
                    tmr_value <= tmr_value - 1'b1;
                end
            end
            if (tmr_tc)                                  tmr_flag <= 1'b1;
            else if (wr && word == 6'h05 && host_wdata[3]) tmr_flag <= 1'b0;
            if (wr && word == 6'h05) begin
                tmr_en <= host_wdata[0];
                tmr_ar <= host_wdata[1];
                tmr_ie <= host_wdata[2];
            end
            if (wr && word == 6'h06) begin
                tmr_period <= host_wdata[TIMER_WIDTH-1:0];
                tmr_value  <= host_wdata[TIMER_WIDTH-1:0];
            end
            tmr_irq <= tmr_flag & tmr_ie;
        end
    end

    assign timer_irq_o = tmr_irq;
`else
    assign timer_irq_o = 1'b0;
`endif

    always_comb begin
        rdata_next = '0;
        case (word)
            6'h00: rdata_next = IDCODE;
            6'h01: rdata_next = {31'b0, cpu_reset};
            6'h02: rdata_next = CORENUM;
            6'h04: rdata_next = {16'b0, 8'(count), 5'b0, overflow, fifo_full, fifo_empty};
`ifdef SFR_TIMER_EN
            6'h05: rdata_next = {28'b0, tmr_flag, tmr_ie, tmr_ar, tmr_en};
            6'h06: rdata_next = 32'(tmr_period);
            6'h07: rdata_next = 32'(tmr_value);
`endif
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (scr_hit && scr_idx == 6'(i)) rdata_next = scratch[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        cpu_reset_o <= rst_i | cpu_reset;
        if (rst_i) begin
            host_resp  <= 1'b0;
            host_rdata <= '0;
            cpu_reset  <= CPU_RESET_DEFAULT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
            for (int i = 0; i < SCR_N; i++) scratch[i] <= '0;
        end else begin
            host_resp  <= rd;
            host_rdata <= rd ? rdata_next : '0;

            if (wr && word == 6'h01) cpu_reset <= host_wdata[0];

            if (push_ok) begin
                fifo_mem[wr_ptr] <= host_wdata[IRQ_NUM_POW-1:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;

            if (push && !push_ok)                          overflow <= 1'b1;
            else if (wr && word == 6'h04 && host_wdata[2]) overflow <= 1'b0;

            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr && scr_hit && scr_idx == 6'(i)) scratch[i] <= host_wdata;
            end
        end
    end

endmodule
